// File: rtl/mdc_pkg.sv
// mdc_pkg: values shared by the input-conditioning stage and the controller bench.
//   - coin code encoding and its credit value
//   - brew-timer state encoding
//   - default prices, credit ceiling and brew times
package mdc_pkg;

  localparam logic [1:0] MONEDA_25  = 2'd0;
  localparam logic [1:0] MONEDA_50  = 2'd1;
  localparam logic [1:0] MONEDA_100 = 2'd2;
  localparam logic [1:0] MONEDA_INV = 2'd3;

  localparam logic [7:0]  PRECIO_P_DEF    = 8'd100;
  localparam logic [7:0]  PRECIO_G_DEF    = 8'd150;
  localparam logic [7:0]  CREDITO_MAX_DEF = 8'd250;
  localparam logic [15:0] T_PEQ_DEF       = 16'd5;
  localparam logic [15:0] T_GRA_DEF       = 16'd8;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_CUENTA = 2'd1,
    T_FIN    = 2'd2
  } tm_estado_e;

  // Credit units for a coin code; the invalid code is worth nothing.
  function automatic logic [7:0] valor_moneda(input logic [1:0] cod);
    case (cod)
      MONEDA_25:  valor_moneda = 8'd25;
      MONEDA_50:  valor_moneda = 8'd50;
      MONEDA_100: valor_moneda = 8'd100;
      default:    valor_moneda = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdc_antirrebote.sv
// mdc_antirrebote: two-flop synchroniser plus debounce for one raw button.
//   clk    in  system clock
//   rst    in  synchronous reset, active-high
//   raw    in  raw button level, asynchronous, active-high
//   evento out one-cycle pulse when the press has been stable DEB_CICLOS cycles
// The counter saturates at DEB_CICLOS, so a held button yields exactly one
// event; only a release (synced level 0) clears it and re-arms the detector.
module mdc_antirrebote #(
  parameter int DEB_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evento
);

  localparam int CW = $clog2(DEB_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CICLOS);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      evento <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      evento <= 1'b0;
      if (s2) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end
        // fires on the step that brings the count to DEB_CICLOS
        evento <= (cnt == CNT_MAX - CW'(1));
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mdc_acondicionador.sv
// mdc_acondicionador: conditions the raw machine inputs into the six active-low
// condition lines of the coffee controller.
//   clk, rst         clock and synchronous active-high reset
//   btn_p_raw/g_raw  raw size buttons
//   moneda_valid/val coin pulse and code
//   nivel_*_raw      raw water/coffee level sensors
//   pedido_ack       controller consumed the pending request
//   cobrar           deduct price of the latched size
//   tm_start         start/restart brew timer
//   hm ha bp bb hc tm condition lines (0 = asserted)
//   credito          current credit
//   estado_tm        brew-timer state, for observation
// Handshakes: moneda_valid, cobrar, tm_start and pedido_ack are single-cycle
// pulses sampled on the rising edge; there is no back-pressure.
module mdc_acondicionador
  import mdc_pkg::*;
#(
  parameter int          DEB_CICLOS  = 4,
  parameter logic [7:0]  PRECIO_P    = PRECIO_P_DEF,
  parameter logic [7:0]  PRECIO_G    = PRECIO_G_DEF,
  parameter logic [7:0]  CREDITO_MAX = CREDITO_MAX_DEF,
  parameter logic [15:0] T_PEQ       = T_PEQ_DEF,
  parameter logic [15:0] T_GRA       = T_GRA_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_p_raw,
  input  logic       btn_g_raw,
  input  logic       moneda_valid,
  input  logic [1:0] moneda_val,
  input  logic       nivel_agua_raw,
  input  logic       nivel_cafe_raw,
  input  logic       pedido_ack,
  input  logic       cobrar,
  input  logic       tm_start,
  output logic       hm,
  output logic       ha,
  output logic       bp,
  output logic       bb,
  output logic       hc,
  output logic       tm,
  output logic [7:0] credito,
  output tm_estado_e estado_tm
);

  // ---------------- sensors ----------------
  logic [1:0] agua_sync;
  logic [1:0] cafe_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      agua_sync <= 2'b00;
      cafe_sync <= 2'b00;
    end else begin
      agua_sync <= {agua_sync[0], nivel_agua_raw};
      cafe_sync <= {cafe_sync[0], nivel_cafe_raw};
    end
  end

  assign ha = ~agua_sync[1];
  assign hc = ~cafe_sync[1];

  // ---------------- buttons / request ----------------
  logic ev_p;
  logic ev_g;
  logic req;
  logic tamano;  // 0 = small, 1 = large

  mdc_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_p (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_p_raw),
    .evento (ev_p)
  );

  mdc_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_g (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_g_raw),
    .evento (ev_g)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req    <= 1'b0;
      tamano <= 1'b0;
    end else if (pedido_ack) begin
      req <= 1'b0;
    end else if (!req && (ev_p || ev_g)) begin
      req    <= 1'b1;
      tamano <= ~ev_p;  // small wins a tie
    end
  end

  assign bp = ~(req & ~tamano);
  assign bb = ~(req & tamano);

  // ---------------- credit ----------------
  logic [7:0] precio;
  logic [7:0] cred_ded;
  logic [8:0] suma;
  logic [7:0] credito_next;

  // Deduction is applied before the coin so a same-cycle coin cannot fund it.
  always_comb begin
    precio   = tamano ? PRECIO_G : PRECIO_P;
    cred_ded = credito;
    if (cobrar && (credito >= precio)) begin
      cred_ded = credito - precio;
    end
    suma = {1'b0, cred_ded};
    if (moneda_valid && (moneda_val != MONEDA_INV)) begin
      suma = suma + {1'b0, valor_moneda(moneda_val)};
    end
    credito_next = (suma > {1'b0, CREDITO_MAX}) ? CREDITO_MAX : suma[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credito <= 8'd0;
      hm      <= 1'b1;
    end else begin
      credito <= credito_next;
      hm      <= ~(credito_next >= PRECIO_P);
    end
  end

  // ---------------- brew timer ----------------
  tm_estado_e  estado;
  tm_estado_e  estado_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= T_IDLE;
      cnt    <= 16'd0;
    end else begin
      estado <= estado_next;
      cnt    <= cnt_next;
    end
  end

  // Loading T-1 and leaving on cnt==0 makes tm fall T edges after tm_start.
  always_comb begin
    estado_next = estado;
    cnt_next    = cnt;
    tm          = (estado != T_FIN);
    if (tm_start) begin
      cnt_next    = (tamano ? T_GRA : T_PEQ) - 16'd1;
      estado_next = T_CUENTA;
    end else begin
      case (estado)
        T_CUENTA: begin
          if (cnt == 16'd0) begin
            estado_next = T_FIN;
          end else begin
            cnt_next = cnt - 16'd1;
          end
        end
        default: begin
          estado_next = estado;
        end
      endcase
    end
  end

  assign estado_tm = estado;

endmodule

// File: tb/tb_mdc_acondicionador.sv
module tb_mdc_acondicionador;
  import mdc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       btn_p_raw, btn_g_raw, moneda_valid, nivel_agua_raw, nivel_cafe_raw;
  logic       pedido_ack, cobrar, tm_start;
  logic [1:0] moneda_val;
  logic       hm, ha, bp, bb, hc, tm;
  logic [7:0] credito;
  tm_estado_e estado_tm;

  mdc_acondicionador dut (
    .clk            (clk),
    .rst            (rst),
    .btn_p_raw      (btn_p_raw),
    .btn_g_raw      (btn_g_raw),
    .moneda_valid   (moneda_valid),
    .moneda_val     (moneda_val),
    .nivel_agua_raw (nivel_agua_raw),
    .nivel_cafe_raw (nivel_cafe_raw),
    .pedido_ack     (pedido_ack),
    .cobrar         (cobrar),
    .tm_start       (tm_start),
    .hm             (hm),
    .ha             (ha),
    .bp             (bp),
    .bb             (bb),
    .hc             (hc),
    .tm             (tm),
    .credito        (credito),
    .estado_tm      (estado_tm)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] v, input logic cob);
    moneda_valid = 1'b1;
    moneda_val   = v;
    cobrar       = cob;
    tick();
    moneda_valid = 1'b0;
    cobrar       = 1'b0;
  endtask

  task automatic pulse_cobrar();
    cobrar = 1'b1;
    tick();
    cobrar = 1'b0;
  endtask

  task automatic pulse_ack();
    pedido_ack = 1'b1;
    tick();
    pedido_ack = 1'b0;
  endtask

  typedef struct {
    logic [1:0] val;
    logic [7:0] exp_cred;
    logic       exp_hm;
  } moneda_vec_t;

  moneda_vec_t tabla[7];

  initial begin
    tabla[0] = '{MONEDA_50,  8'd50,  1'b1};
    tabla[1] = '{MONEDA_25,  8'd75,  1'b1};
    tabla[2] = '{MONEDA_25,  8'd100, 1'b0};
    tabla[3] = '{MONEDA_100, 8'd200, 1'b0};
    tabla[4] = '{MONEDA_100, 8'd250, 1'b0};
    tabla[5] = '{MONEDA_100, 8'd250, 1'b0};
    tabla[6] = '{MONEDA_INV, 8'd250, 1'b0};

    btn_p_raw = 0; btn_g_raw = 0; moneda_valid = 0; moneda_val = 0;
    nivel_agua_raw = 0; nivel_cafe_raw = 0; pedido_ack = 0; cobrar = 0; tm_start = 0;
    rst = 0;
    #1;
    do_reset(2);

    // reset state
    chk("rst_hm", 16'(hm), 16'd1);
    chk("rst_ha", 16'(ha), 16'd1);
    chk("rst_bp", 16'(bp), 16'd1);
    chk("rst_bb", 16'(bb), 16'd1);
    chk("rst_hc", 16'(hc), 16'd1);
    chk("rst_tm", 16'(tm), 16'd1);
    chk("rst_credito", 16'(credito), 16'd0);
    chk("rst_estado", 16'(estado_tm), 16'(T_IDLE));

    // sensor latency: 2 edges
    nivel_agua_raw = 1'b1;
    nivel_cafe_raw = 1'b1;
    tick();
    chk("ha_lat1", 16'(ha), 16'd1);
    chk("hc_lat1", 16'(hc), 16'd1);
    tick();
    chk("ha_lat2", 16'(ha), 16'd0);
    chk("hc_lat2", 16'(hc), 16'd0);

    // coin table
    for (int i = 0; i < 7; i++) begin
      coin(tabla[i].val, 1'b0);
      chk($sformatf("coin%0d_credito", i), 16'(credito), 16'(tabla[i].exp_cred));
      chk($sformatf("coin%0d_hm", i), 16'(hm), 16'(tabla[i].exp_hm));
    end

    // glitched press: synced run never reaches 4
    btn_p_raw = 1; tick();
    btn_p_raw = 0; tick();
    btn_p_raw = 1; tick();
    btn_p_raw = 1; tick();
    btn_p_raw = 0;
    ticks(8);
    chk("glitch_bp", 16'(bp), 16'd1);
    chk("glitch_bb", 16'(bb), 16'd1);

    // clean held press
    btn_p_raw = 1;
    ticks(10);
    chk("small_bp", 16'(bp), 16'd0);
    chk("small_bb", 16'(bb), 16'd1);
    pulse_ack();
    chk("ack_bp", 16'(bp), 16'd1);
    ticks(10);
    chk("held_no_second_bp", 16'(bp), 16'd1);
    btn_p_raw = 0;
    ticks(5);

    // large request and guarded deduction
    do_reset(1);
    chk("rst2_credito", 16'(credito), 16'd0);
    btn_g_raw = 1;
    ticks(10);
    btn_g_raw = 0;
    chk("large_bb", 16'(bb), 16'd0);
    chk("large_bp", 16'(bp), 16'd1);
    coin(MONEDA_100, 1'b0);
    chk("large_cred100", 16'(credito), 16'd100);
    pulse_cobrar();
    chk("cobrar_short_credito", 16'(credito), 16'd100);
    chk("cobrar_short_hm", 16'(hm), 16'd0);
    coin(MONEDA_50, 1'b0);
    chk("large_cred150", 16'(credito), 16'd150);
    pulse_cobrar();
    chk("cobrar_ok_credito", 16'(credito), 16'd0);
    chk("cobrar_ok_hm", 16'(hm), 16'd1);

    // brew timer, large (8 cycles)
    tm_start = 1;
    tick();
    tm_start = 0;
    chk("tm_start_estado", 16'(estado_tm), 16'(T_CUENTA));
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("tm_cycle%0d", k), 16'(tm), 16'd1);
    end
    tick();
    chk("tm_cycle8", 16'(tm), 16'd0);
    ticks(3);
    chk("tm_held", 16'(tm), 16'd0);
    tm_start = 1;
    tick();
    tm_start = 0;
    chk("tm_restart", 16'(tm), 16'd1);
    chk("tm_restart_estado", 16'(estado_tm), 16'(T_CUENTA));
    ticks(3);
    do_reset(1);
    chk("rst_mid_tm", 16'(tm), 16'd1);
    chk("rst_mid_estado", 16'(estado_tm), 16'(T_IDLE));
    chk("rst_mid_bb", 16'(bb), 16'd1);

    // small timer (5 cycles), tamano back to small after reset
    tm_start = 1;
    tick();
    tm_start = 0;
    ticks(4);
    chk("tm_small_4", 16'(tm), 16'd1);
    tick();
    chk("tm_small_5", 16'(tm), 16'd0);

    // coin and cobrar in the same cycle (small, credit 100)
    coin(MONEDA_100, 1'b0);
    chk("same_pre_credito", 16'(credito), 16'd100);
    coin(MONEDA_100, 1'b1);
    chk("same_cycle_credito", 16'(credito), 16'd100);
    chk("same_cycle_hm", 16'(hm), 16'd0);

    // both buttons accepted together: small wins
    btn_p_raw = 1;
    btn_g_raw = 1;
    ticks(10);
    chk("both_bp", 16'(bp), 16'd0);
    chk("both_bb", 16'(bb), 16'd1);
    btn_p_raw = 0;
    btn_g_raw = 0;
    pulse_ack();
    chk("both_ack_bp", 16'(bp), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdc_acondicionador.md
Name: mdc_acondicionador

Overview:
- Input-conditioning stage directly upstream of the coffee-machine controller (Controlador); produces its six condition inputs Condicion1..Condicion6 (hm, ha, bp, bb, hc, tm).
- Debounces the size buttons, accumulates coin credit, synchronises the level sensors and runs the brew timer.
- All condition outputs are active-low, matching the controller: idle = 1, asserted = 0.

Parameters:
- DEB_CICLOS, 4, stable cycles a raw button must hold before it is accepted.
- PRECIO_P, 8'd100, price of small coffee in credit units.
- PRECIO_G, 8'd150, price of large coffee in credit units.
- CREDITO_MAX, 8'd250, credit saturation value.
- T_PEQ, 16'd5, brew-timer cycles for small.
- T_GRA, 16'd8, brew-timer cycles for large.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- btn_p_raw  in  1  raw small-coffee button, active-high, asynchronous.
- btn_g_raw  in  1  raw large-coffee button, active-high, asynchronous.
- moneda_valid  in  1  one-cycle coin pulse.
- moneda_val  in  2  coin value: 0=25, 1=50, 2=100, 3=invalid/ignored.
- nivel_agua_raw  in  1  water present, active-high, asynchronous.
- nivel_cafe_raw  in  1  coffee present, active-high, asynchronous.
- pedido_ack  in  1  controller consumed the button request (one of its salida lines).
- cobrar  in  1  one-cycle pulse: deduct price of the latched size.
- tm_start  in  1  one-cycle pulse: start brew timer.
- hm  out  1  low = credit >= PRECIO_P.
- ha  out  1  low = water present.
- bp  out  1  low = small request pending.
- bb  out  1  low = large request pending.
- hc  out  1  low = coffee present.
- tm  out  1  low = brew time elapsed.
- credito  out  8  current credit, unsigned.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): all six condition outputs = 1, credito = 0, debounce counters = 0, synchronisers = 0, timer state = T_IDLE, tamano = 0 (small).
- Sensors:
  - Two-flop synchroniser on each raw sensor.
  - ha = ~sync(nivel_agua_raw) and hc = ~sync(nivel_cafe_raw); latency 2 cycles from the raw edge.
- Buttons:
  - Two-flop synchroniser, then a per-button counter that increments while the synced level is 1 and clears to 0 when it is 0.
  - When the counter reaches DEB_CICLOS, one acceptance event fires; no further event until the button has been released (synced level back to 0).
  - An accepted event with no request pending sets the request and latches tamano (0 = small, 1 = large).
  - bp = ~(req & ~tamano); bb = ~(req & tamano).
  - Events accepted while a request is pending are ignored.
  - If both buttons are accepted in the same cycle, small wins.
  - pedido_ack clears req on the next edge; if ack and a new acceptance coincide, ack wins.
- Credit:
  - On moneda_valid with a valid code: credito = min(credito + value, CREDITO_MAX), computed in 9 bits and then saturated.
  - On cobrar: credito -= price of tamano only if credito >= price; otherwise unchanged, with no underflow.
  - moneda_valid and cobrar in the same cycle: apply the deduction first, then the addition, both in that cycle.
  - hm is registered: hm = ~(credito_next >= PRECIO_P).
- Brew timer FSM, states T_IDLE, T_CUENTA, T_FIN:
  - T_IDLE: tm = 1. tm_start loads cnt = (tamano ? T_GRA : T_PEQ) - 1 and goes to T_CUENTA.
  - T_CUENTA: decrement cnt; at cnt == 0 go to T_FIN.
  - T_FIN: tm = 0, held until the next tm_start, which reloads and returns to T_CUENTA with tm = 1.
  - tm_start during T_CUENTA restarts the count.
  - tm goes low exactly T cycles after the tm_start edge.
- Reset mid-operation aborts the timer, clears credit and the pending request, and restores all outputs to 1 on the same edge.

Decomposition:
- Shared package mdc_pkg:
  - coin-value encoding constants;
  - timer state enum (T_IDLE, T_CUENTA, T_FIN);
  - PRECIO_* and T_* defaults, for reuse by the controller bench.
- One natural sub-module, mdc_antirrebote (synchroniser + debounce + single-event-per-press); instantiate it twice.

Test Plan:
- Reset held 2 cycles -> all conditions = 1, credito = 0; raise nivel_agua_raw -> ha = 0 exactly 2 cycles later.
- Coins 50, 25, 25 -> credito 50, 75, 100; hm falls to 0 on the third coin; coins to 250, then +100 -> credito stays 250.
- Small button held 4 cycles with a 1-cycle glitch at cycle 2 -> no request; held 6 clean cycles -> bp = 0, bb = 1; pedido_ack -> bp = 1 next cycle; held press yields no second request.
- Large request, credito = 100, cobrar -> credito stays 100; add 50, cobrar -> credito = 0, hm = 1.
- Large request then tm_start -> tm = 1 for 7 cycles, 0 on the 8th, held; tm_start again -> tm = 1; rst mid-count -> tm = 1 and FSM in T_IDLE.
- Coin 100 and cobrar (small, credito = 100) in the same cycle -> credito = 100.
